// File: rtl/xor_stream_cipher.sv
// XOR stream cipher: each accepted pixel is XORed with a key word popped from an
// internal key FIFO; a start/done frame FSM delivers exactly FRAME_LEN beats per frame.
module xor_stream_cipher #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 786432,
    parameter int CNT_W     = 20,
    parameter int KEY_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bypass,
    input  logic [DATA_W-1:0]            s_pix_tdata,
    input  logic                         s_pix_tvalid,
    output logic                         s_pix_tready,
    input  logic [DATA_W-1:0]            s_key_tdata,
    input  logic                         s_key_tvalid,
    output logic                         s_key_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(KEY_DEPTH):0]   key_level
);

    localparam int AW = $clog2(KEY_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [LW-1:0]    FULL_LVL = LW'(KEY_DEPTH);

    // IDLE: wait for start | RUN: accept beats | FLUSH: drain last beat | DONE: hold done
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_key_mem [KEY_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic [CNT_W-1:0]    r_count;
    logic                r_bypass_q;
    logic                r_done;
    logic [DATA_W-1:0]   r_m_tdata;
    logic                r_m_tvalid;
    logic                r_m_tlast;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_acc;
    logic                w_last_beat;
    logic                w_out_hs;
    logic [DATA_W-1:0]   w_head;

    assign w_full       = (r_level == FULL_LVL);
    assign w_empty      = (r_level == '0);
    assign s_key_tready = !w_full && !rst;
    assign w_push       = s_key_tvalid && s_key_tready;

    assign s_pix_tready = (r_state == S_RUN) && (r_bypass_q || !w_empty)
                          && (!r_m_tvalid || m_tready) && !rst;
    assign w_acc        = s_pix_tvalid && s_pix_tready;
    // Readiness already requires a key unless bypassing, so a pop never hits an empty FIFO.
    assign w_pop        = w_acc && !r_bypass_q;
    assign w_head       = r_key_mem[r_rd_ptr];
    assign w_last_beat  = (r_count == LAST_CNT);
    assign w_out_hs     = r_m_tvalid && m_tready;

    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign done      = r_done;
    assign busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign key_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_key_mem[r_wr_ptr] <= s_key_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_bypass_q <= 1'b0;
            r_done     <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_m_tdata  <= r_bypass_q ? s_pix_tdata : (s_pix_tdata ^ w_head);
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_last_beat;
            end else if (w_out_hs) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_count    <= '0;
                        r_bypass_q <= bypass;
                        r_done     <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Counter parks at FRAME_LEN-1 on the final beat instead of wrapping.
                    if (w_acc) begin
                        if (w_last_beat) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_out_hs && r_m_tlast) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
